// File: rtl/mdu_issue_queue_pkg.sv
// Shared types for the MDU issue queue: opcodes, divider request and queue entry layouts.
package mdu_issue_queue_pkg;

    localparam int unsigned ROB_WIDTH = 6;

    typedef enum logic [2:0] {
        MduMul    = 3'd0,
        MduMulh   = 3'd1,
        MduMulhsu = 3'd2,
        MduMulhu  = 3'd3,
        MduDiv    = 3'd4,
        MduDivu   = 3'd5,
        MduRem    = 3'd6,
        MduRemu   = 3'd7
    } mdu_op_e;

    // data[0] is the dividend, data[1] the divisor.
    typedef struct packed {
        mdu_op_e                op;
        logic [ROB_WIDTH-1:0]   reg_id;
        logic [1:0][31:0]       data;
    } mdu_i_t;

    typedef struct packed {
        logic                       valid;
        mdu_op_e                    op;
        logic [ROB_WIDTH-1:0]       reg_id;
        logic [1:0]                 src_rdy;
        logic [1:0][ROB_WIDTH-1:0]  src_tag;
        logic [1:0][31:0]           src_data;
    } mdu_iq_entry_t;

    function automatic mdu_i_t entry_to_req(mdu_iq_entry_t e);
        mdu_i_t r;
        r.op     = e.op;
        r.reg_id = e.reg_id;
        r.data   = e.src_data;
        return r;
    endfunction

endpackage

// File: rtl/mdu_issue_queue_if.sv
// Dispatch, writeback-snoop and divider-request signals of the MDU issue queue.
interface mdu_issue_queue_if #(
    parameter int unsigned WB_PORTS = 2
);
    import mdu_issue_queue_pkg::*;

    logic                                disp_valid_i;
    logic                                disp_ready_o;
    mdu_op_e                             disp_op_i;
    logic [ROB_WIDTH-1:0]                disp_reg_id_i;
    logic [1:0]                          disp_src_rdy_i;
    logic [1:0][ROB_WIDTH-1:0]           disp_src_tag_i;
    logic [1:0][31:0]                    disp_src_data_i;
    logic [WB_PORTS-1:0]                 wb_valid_i;
    logic [WB_PORTS-1:0][ROB_WIDTH-1:0]  wb_tag_i;
    logic [WB_PORTS-1:0][31:0]           wb_data_i;
    mdu_i_t                              req_o;
    logic                                valid_o;
    logic                                ready_i;

    modport master (
        output disp_valid_i, disp_op_i, disp_reg_id_i, disp_src_rdy_i, disp_src_tag_i,
        output disp_src_data_i, wb_valid_i, wb_tag_i, wb_data_i, ready_i,
        input  disp_ready_o, req_o, valid_o
    );

    modport slave (
        input  disp_valid_i, disp_op_i, disp_reg_id_i, disp_src_rdy_i, disp_src_tag_i,
        input  disp_src_data_i, wb_valid_i, wb_tag_i, wb_data_i, ready_i,
        output disp_ready_o, req_o, valid_o
    );

endinterface

// File: rtl/mdu_iq_wakeup.sv
// Combinational operand wakeup: captures writeback data for a pending operand by tag match.
module mdu_iq_wakeup
    import mdu_issue_queue_pkg::*;
#(
    parameter int unsigned WB_PORTS = 2
) (
    input  logic                                rdy_i,
    input  logic [ROB_WIDTH-1:0]                tag_i,
    input  logic [31:0]                         data_i,
    input  logic [WB_PORTS-1:0]                 wb_valid_i,
    input  logic [WB_PORTS-1:0][ROB_WIDTH-1:0]  wb_tag_i,
    input  logic [WB_PORTS-1:0][31:0]           wb_data_i,
    output logic                                rdy_o,
    output logic [31:0]                         data_o
);

    logic hit;

    // A ready operand is never overwritten; lowest matching port wins.
    always_comb begin
        hit    = 1'b0;
        rdy_o  = rdy_i;
        data_o = data_i;
        if (!rdy_i) begin
            for (int unsigned p = 0; p < WB_PORTS; p++) begin
                if (!hit && wb_valid_i[p] && (wb_tag_i[p] == tag_i)) begin
                    hit    = 1'b1;
                    rdy_o  = 1'b1;
                    data_o = wb_data_i[p];
                end
            end
        end
    end

endmodule

// File: rtl/mdu_issue_queue.sv
// In-order MDU issue buffer: holds dispatched ops until both operands arrive, then issues the head.
module mdu_issue_queue
    import mdu_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned WB_PORTS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    mdu_issue_queue_if.slave  bus_io
);

    localparam int unsigned    PtrW    = $clog2(DEPTH);
    localparam int unsigned    CntW    = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    mdu_iq_entry_t              entries_q [DEPTH];
    mdu_iq_entry_t              entries_d [DEPTH];
    logic [PtrW-1:0]            head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]            count_q, count_d;

    logic [DEPTH-1:0][1:0]        wake_rdy;
    logic [DEPTH-1:0][1:0][31:0]  wake_data;
    logic [1:0]                   byp_rdy;
    logic [1:0][31:0]             byp_data;

    mdu_iq_entry_t head;
    logic          push, pop;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        for (genvar s = 0; s < 2; s++) begin : g_src
            mdu_iq_wakeup #(
                .WB_PORTS (WB_PORTS)
            ) u_wake (
                .rdy_i      (entries_q[i].src_rdy[s]),
                .tag_i      (entries_q[i].src_tag[s]),
                .data_i     (entries_q[i].src_data[s]),
                .wb_valid_i (bus_io.wb_valid_i),
                .wb_tag_i   (bus_io.wb_tag_i),
                .wb_data_i  (bus_io.wb_data_i),
                .rdy_o      (wake_rdy[i][s]),
                .data_o     (wake_data[i][s])
            );
        end
    end

    for (genvar s = 0; s < 2; s++) begin : g_byp
        mdu_iq_wakeup #(
            .WB_PORTS (WB_PORTS)
        ) u_byp (
            .rdy_i      (bus_io.disp_src_rdy_i[s]),
            .tag_i      (bus_io.disp_src_tag_i[s]),
            .data_i     (bus_io.disp_src_data_i[s]),
            .wb_valid_i (bus_io.wb_valid_i),
            .wb_tag_i   (bus_io.wb_tag_i),
            .wb_data_i  (bus_io.wb_data_i),
            .rdy_o      (byp_rdy[s]),
            .data_o     (byp_data[s])
        );
    end

    // Outputs depend on registered state only; no path from ready_i to disp_ready_o.
    assign head                = entries_q[head_q];
    assign bus_io.valid_o      = head.valid & (&head.src_rdy);
    assign bus_io.disp_ready_o = (count_q != CntFull);
    assign bus_io.req_o        = entry_to_req(head);

    assign push = bus_io.disp_valid_i & bus_io.disp_ready_o & ~flush;
    assign pop  = bus_io.valid_o & bus_io.ready_i & ~flush;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid) begin
                entries_d[i].src_rdy  = wake_rdy[i];
                entries_d[i].src_data = wake_data[i];
            end
        end

        if (pop) begin
            entries_d[head_q] = '0;
            head_d            = head_q + 1'b1;
        end

        if (push) begin
            entries_d[tail_q].valid    = 1'b1;
            entries_d[tail_q].op       = bus_io.disp_op_i;
            entries_d[tail_q].reg_id   = bus_io.disp_reg_id_i;
            entries_d[tail_q].src_rdy  = byp_rdy;
            entries_d[tail_q].src_tag  = bus_io.disp_src_tag_i;
            entries_d[tail_q].src_data = byp_data;
            tail_d                     = tail_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entries_q <= '{default: '0};
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_mdu_issue_queue.sv
// Self-checking bench for mdu_issue_queue: directed scenarios plus random traffic vs a queue model.
module tb_mdu_issue_queue;
    import mdu_issue_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WBP   = 2;

    typedef struct packed {
        mdu_op_e                    op;
        logic [ROB_WIDTH-1:0]       rid;
        logic [1:0]                 rdy;
        logic [1:0][ROB_WIDTH-1:0]  tag;
        logic [1:0][31:0]           data;
    } m_ent_t;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    logic   flush = 1'b0;
    int     checks = 0;
    int     errors = 0;
    m_ent_t mq[$];

    mdu_issue_queue_if #(.WB_PORTS(WBP)) bus ();

    mdu_issue_queue #(
        .DEPTH    (DEPTH),
        .WB_PORTS (WBP)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic mdu_i_t mk_req(mdu_op_e op, logic [ROB_WIDTH-1:0] rid,
                                      logic [31:0] d0, logic [31:0] d1);
        mdu_i_t r;
        r.op      = op;
        r.reg_id  = rid;
        r.data[0] = d0;
        r.data[1] = d1;
        return r;
    endfunction

    task automatic idle();
        bus.disp_valid_i    = 1'b0;
        bus.disp_op_i       = MduMul;
        bus.disp_reg_id_i   = '0;
        bus.disp_src_rdy_i  = '0;
        bus.disp_src_tag_i  = '0;
        bus.disp_src_data_i = '0;
        bus.wb_valid_i      = '0;
        bus.wb_tag_i        = '0;
        bus.wb_data_i       = '0;
    endtask

    task automatic disp(input mdu_op_e op, input logic [ROB_WIDTH-1:0] rid, input logic [1:0] rdy,
                        input logic [ROB_WIDTH-1:0] t0, input logic [ROB_WIDTH-1:0] t1,
                        input logic [31:0] d0, input logic [31:0] d1);
        bus.disp_valid_i       = 1'b1;
        bus.disp_op_i          = op;
        bus.disp_reg_id_i      = rid;
        bus.disp_src_rdy_i     = rdy;
        bus.disp_src_tag_i[0]  = t0;
        bus.disp_src_tag_i[1]  = t1;
        bus.disp_src_data_i[0] = d0;
        bus.disp_src_data_i[1] = d1;
    endtask

    task automatic wb(input int p, input logic [ROB_WIDTH-1:0] tag, input logic [31:0] data);
        bus.wb_valid_i[p] = 1'b1;
        bus.wb_tag_i[p]   = tag;
        bus.wb_data_i[p]  = data;
    endtask

    // Scan ports high to low so the lowest matching port's data is the one left standing.
    function automatic m_ent_t wake(m_ent_t e);
        for (int s = 0; s < 2; s++) begin
            if (!e.rdy[s]) begin
                for (int p = WBP - 1; p >= 0; p--) begin
                    if (bus.wb_valid_i[p] && bus.wb_tag_i[p] == e.tag[s]) begin
                        e.rdy[s]  = 1'b1;
                        e.data[s] = bus.wb_data_i[p];
                    end
                end
            end
        end
        return e;
    endfunction

    // Check outputs of the current state, advance the model with the driven inputs, clock once.
    task automatic cycle();
        bit     exp_v;
        bit     do_push;
        m_ent_t ne;
        exp_v = (mq.size() > 0) && (mq[0].rdy == 2'b11);
        chk("valid_o", bus.valid_o, exp_v);
        chk("disp_ready_o", bus.disp_ready_o, mq.size() != DEPTH);
        if (exp_v) begin
            chk("req_o", bus.req_o, mk_req(mq[0].op, mq[0].rid, mq[0].data[0], mq[0].data[1]));
        end
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            do_push = bus.disp_valid_i && (mq.size() < DEPTH);
            for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
            if (exp_v && bus.ready_i) void'(mq.pop_front());
            if (do_push) begin
                ne.op   = bus.disp_op_i;
                ne.rid  = bus.disp_reg_id_i;
                ne.rdy  = bus.disp_src_rdy_i;
                ne.tag  = bus.disp_src_tag_i;
                ne.data = bus.disp_src_data_i;
                mq.push_back(wake(ne));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        bus.ready_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", bus.valid_o, 1'b0);
        chk("rst_disp_ready", bus.disp_ready_o, 1'b1);
        chk("rst_req_zero", bus.req_o, '0);
        rst_n = 1'b1;

        // Both operands ready: issue next cycle, pop immediately.
        bus.ready_i = 1'b1;
        disp(MduDiv, 6'd5, 2'b11, 6'd0, 6'd0, 32'd100, 32'd7);
        cycle();
        idle();
        chk("ready_ops_req", bus.req_o, mk_req(MduDiv, 6'd5, 32'd100, 32'd7));
        cycle();
        cycle();

        // Pending divisor woken by port 1 after three cycles.
        disp(MduRem, 6'd1, 2'b01, 6'd0, 6'd9, 32'd50, 32'd0);
        cycle();
        idle();
        repeat (3) cycle();
        wb(1, 6'd9, 32'd3);
        cycle();
        idle();
        chk("pending_valid", bus.valid_o, 1'b1);
        chk("pending_data1", bus.req_o, mk_req(MduRem, 6'd1, 32'd50, 32'd3));
        cycle();

        // Same-cycle bypass on the dividend.
        disp(MduDivu, 6'd2, 2'b10, 6'd12, 6'd0, 32'd0, 32'd5);
        wb(0, 6'd12, 32'hFFFF_FFF0);
        cycle();
        idle();
        chk("bypass_req", bus.req_o, mk_req(MduDivu, 6'd2, 32'hFFFF_FFF0, 32'd5));
        cycle();

        // Fill under backpressure, reject the fifth, then drain with push+pop at count 3.
        bus.ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(MduDivu, ROB_WIDTH'(20 + k), 2'b11, 6'd0, 6'd0, 32'(1000 + k), 32'(3 + k));
            cycle();
        end
        chk("full_disp_ready", bus.disp_ready_o, 1'b0);
        disp(MduRem, 6'd24, 2'b11, 6'd0, 6'd0, 32'd1, 32'd1);
        cycle();
        idle();
        cycle();
        chk("stall_req_stable", bus.req_o, mk_req(MduDivu, 6'd20, 32'd1000, 32'd3));
        cycle();
        bus.ready_i = 1'b1;
        cycle();
        disp(MduRem, 6'd25, 2'b11, 6'd0, 6'd0, 32'd77, 32'd11);
        cycle();
        idle();
        repeat (5) cycle();

        // Head waits on tag 4 while the younger entry is ready.
        disp(MduDiv, 6'd30, 2'b10, 6'd4, 6'd0, 32'd0, 32'd2);
        cycle();
        disp(MduDiv, 6'd31, 2'b11, 6'd0, 6'd0, 32'd8, 32'd4);
        cycle();
        idle();
        repeat (3) cycle();
        chk("head_block_valid", bus.valid_o, 1'b0);
        wb(0, 6'd4, 32'd64);
        cycle();
        idle();
        repeat (3) cycle();

        // Flush with a concurrent dispatch, then the same via reset.
        for (int r = 0; r < 2; r++) begin
            bus.ready_i = 1'b0;
            for (int k = 0; k < 3; k++) begin
                disp(MduMul, ROB_WIDTH'(40 + k), 2'b11, 6'd0, 6'd0, 32'(k), 32'(k));
                cycle();
            end
            disp(MduMulh, 6'd50, 2'b11, 6'd0, 6'd0, 32'd9, 32'd9);
            if (r == 0) flush = 1'b1;
            else rst_n = 1'b0;
            cycle();
            flush = 1'b0;
            rst_n = 1'b1;
            idle();
            chk("flush_valid", bus.valid_o, 1'b0);
            chk("flush_disp_ready", bus.disp_ready_o, 1'b1);
            bus.ready_i = 1'b1;
            disp(MduRemu, 6'd60, 2'b11, 6'd0, 6'd0, 32'd13, 32'd6);
            cycle();
            idle();
            chk("flush_next_req", bus.req_o, mk_req(MduRemu, 6'd60, 32'd13, 32'd6));
            cycle();
        end

        // Random traffic against the model.
        repeat (500) begin
            idle();
            flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1) begin
                disp(mdu_op_e'(3'($urandom_range(0, 7))), ROB_WIDTH'($urandom),
                     2'($urandom), ROB_WIDTH'($urandom_range(0, 15)),
                     ROB_WIDTH'($urandom_range(0, 15)), $urandom, $urandom);
            end
            for (int p = 0; p < WBP; p++) begin
                if ($urandom_range(0, 2) == 0) wb(p, ROB_WIDTH'($urandom_range(0, 15)), $urandom);
            end
            bus.ready_i = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle();
        flush = 1'b0;
        bus.ready_i = 1'b1;
        repeat (4) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
